mem_cycle: RTL and testbench

- Pipeline memory stage, directly upstream of the writeback stage.
- Issues loads/stores from EX/MEM signals onto a req/ack data-memory port.
- Aligns store data and byte-enables; extracts and sign/zero-extends load data.
- Holds the MEM/WB pipeline register that drives the writeback inputs (insn_vldW, ResultSrcW, PCPlus4W, ALU_ResultW, ReadDataW). Stalls upstream while memory is busy.

---
 rtl/mem_cycle.sv | 180 ++++++++++++++++++
 tb/tb_mem_cycle.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cycle.sv
`default_nettype none
// ============================================================================
// Module   : mem_cycle
// Brief    : Pipeline MEM stage: req/ack data-memory access, lane alignment,
//            load extension and the MEM/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_cycle #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        insn_vldM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        stallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        insn_vldW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [1:0]  excW
);

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_WAIT    = 1'b1;
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    logic [0:0]       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             w_req, w_stall;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata, w_ld;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    wire [1:0] w_a        = ALU_ResultM[1:0];
    wire       w_load     = insn_vldM & (ResultSrcM == 2'b01);
    wire       w_acc      = insn_vldM & (MemWriteM | (ResultSrcM == 2'b01));
    wire       w_illegal  = (funct3M == 3'b011) | (funct3M[2:1] == 2'b11);
    wire       w_misalign = (funct3M[1:0] == 2'b01 && w_a[0]) ||
                            (funct3M[1:0] == 2'b10 && w_a != 2'b00);
    wire       w_err      = w_acc & (w_illegal | w_misalign);
    wire       w_go       = w_acc & ~w_err;
    wire       w_timeout  = (r_state == S_WAIT) & ~dmem_ack & (r_cnt == c_timeout);
    wire [1:0] w_exc      = w_err ? 2'b01 : (w_timeout ? 2'b10 : 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_go && !dmem_ack) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = CNT_W'(1);
                end
            end
            default: begin
                if (dmem_ack || r_cnt == c_timeout) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req   = w_go;
                w_stall = w_go & ~dmem_ack;
            end
            default: begin
                w_req   = 1'b1;
                w_stall = ~dmem_ack & (r_cnt != c_timeout);
            end
        endcase
    end

    // Reset forces the handshake outputs low even while the M inputs persist.
    assign dmem_req   = i_rst_n & w_req;
    assign dmem_we    = dmem_req & MemWriteM;
    assign stallM     = i_rst_n & w_stall;
    assign dmem_addr  = {ALU_ResultM[31:2], 2'b00};
    assign dmem_be    = w_be;
    assign dmem_wdata = w_wdata;

    always_comb begin
        w_be    = 4'hF;
        w_wdata = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_a;
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_a;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (w_a)
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            2'b11:   w_byte = dmem_rdata[31:24];
            default: ;
        endcase
        w_half = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld = {24'd0, w_byte};
            3'b101:  w_ld = {16'd0, w_half};
            default: w_ld = dmem_rdata;
        endcase
    end

    // A stalled cycle injects a bubble; the payload fields simply hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            insn_vldW   <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RdW         <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            excW        <= 2'b00;
        end else if (stallM) begin
            insn_vldW   <= 1'b0;
            RegWriteW   <= 1'b0;
            excW        <= 2'b00;
        end else begin
            insn_vldW   <= insn_vldM;
            RegWriteW   <= RegWriteM & (w_exc == 2'b00);
            ResultSrcW  <= ResultSrcM;
            RdW         <= RdM;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= (w_load && w_exc == 2'b00) ? w_ld : 32'd0;
            excW        <= w_exc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_cycle
// Brief    : Directed vector-table bench for mem_cycle plus multi-cycle
//            stall, timeout and mid-access reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_cycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        insn_vldM, RegWriteM, MemWriteM, dmem_ack;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M, dmem_rdata;
    logic        stallM, dmem_req, dmem_we, insn_vldW, RegWriteW;
    logic [31:0] dmem_addr, dmem_wdata, PCPlus4W, ALU_ResultW, ReadDataW;
    logic [3:0]  dmem_be;
    logic [1:0]  ResultSrcW, excW;
    logic [4:0]  RdW;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_cycle #(.TIMEOUT(4), .CNT_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .insn_vldM(insn_vldM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .funct3M(funct3M), .RdM(RdM),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .insn_vldW(insn_vldW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RdW(RdW), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
        .ReadDataW(ReadDataW), .excW(excW)
    );

    typedef struct {
        string       name;
        logic        vld, regw;
        logic [1:0]  rsrc;
        logic        mwe;
        logic [2:0]  f3;
        logic [31:0] alu, wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_vldW, e_regW;
        logic [31:0] e_rdW;
        logic [1:0]  e_exc;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x, input logic [4:0] rd, input logic [31:0] pc);
        insn_vldM   = x.vld;
        RegWriteM   = x.regw;
        ResultSrcM  = x.rsrc;
        MemWriteM   = x.mwe;
        funct3M     = x.f3;
        RdM         = rd;
        ALU_ResultM = x.alu;
        WriteDataM  = x.wd;
        PCPlus4M    = pc;
        dmem_ack    = x.ack;
        dmem_rdata  = x.rdata;
    endtask

    task automatic nop();
        insn_vldM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0;
        funct3M = 3'b000; RdM = 5'd0; ALU_ResultM = 32'd0; WriteDataM = 32'd0;
        PCPlus4M = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    initial begin
        logic [4:0]  rd;
        logic [31:0] pc;
        int          nstall;
        logic        was_stall;

        //       name    vld regw rsrc  mwe f3      alu           wd            ack rdata         req be     wdata         vW rW rdW           exc
        v[0]  = '{"add",  1, 1, 2'b00, 0, 3'b000, 32'h0000_1234, 32'h0,        0, 32'h0,        0, 4'h0, 32'h0,        1, 1, 32'h0,        2'b00};
        v[1]  = '{"sb",   1, 0, 2'b00, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1, 32'h0,       1, 4'h8, 32'hABAB_ABAB, 1, 0, 32'h0,        2'b00};
        v[2]  = '{"lhu",  1, 1, 2'b01, 0, 3'b101, 32'h0000_2002, 32'h0,        1, 32'h8001_0000, 1, 4'h0, 32'h0,        1, 1, 32'h0000_8001, 2'b00};
        v[3]  = '{"lwmis",1, 1, 2'b01, 0, 3'b010, 32'h0000_3002, 32'h0,        1, 32'hFFFF_FFFF, 0, 4'h0, 32'h0,        1, 0, 32'h0,        2'b01};
        v[4]  = '{"ill",  1, 1, 2'b01, 0, 3'b011, 32'h0000_3000, 32'h0,        1, 32'hFFFF_FFFF, 0, 4'h0, 32'h0,        1, 0, 32'h0,        2'b01};
        v[5]  = '{"sh",   1, 0, 2'b00, 1, 3'b001, 32'h0000_1002, 32'h1234_CDEF, 1, 32'h0,       1, 4'hC, 32'hCDEF_CDEF, 1, 0, 32'h0,        2'b00};
        v[6]  = '{"sw",   1, 0, 2'b00, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0,       1, 4'hF, 32'hDEAD_BEEF, 1, 0, 32'h0,        2'b00};
        v[7]  = '{"lb3",  1, 1, 2'b01, 0, 3'b000, 32'h0000_2003, 32'h0,        1, 32'h7F00_0000, 1, 4'h0, 32'h0,        1, 1, 32'h0000_007F, 2'b00};
        v[8]  = '{"lh",   1, 1, 2'b01, 0, 3'b001, 32'h0000_2000, 32'h0,        1, 32'h1234_F00D, 1, 4'h0, 32'h0,        1, 1, 32'hFFFF_F00D, 2'b00};
        v[9]  = '{"lbu",  1, 1, 2'b01, 0, 3'b100, 32'h0000_2001, 32'h0,        1, 32'h0080_FF00, 1, 4'h0, 32'h0,        1, 1, 32'h0000_00FF, 2'b00};
        v[10] = '{"novld",0, 0, 2'b00, 1, 3'b010, 32'h0000_1000, 32'h5555_5555, 1, 32'h0,       0, 4'h0, 32'h0,        0, 0, 32'h0,        2'b00};
        v[11] = '{"shmis",1, 0, 2'b00, 1, 3'b001, 32'h0000_1001, 32'h0000_BEEF, 1, 32'h0,       0, 4'h0, 32'h0,        1, 0, 32'h0,        2'b01};
        v[12] = '{"lhmis",1, 1, 2'b01, 0, 3'b001, 32'h0000_2003, 32'h0,        1, 32'h1111_1111, 0, 4'h0, 32'h0,        1, 0, 32'h0,        2'b01};

        nop();
        rst_n = 1'b0;
        #12;
        chk("rst_vldW", {31'd0, insn_vldW}, 32'd0);
        chk("rst_regW", {31'd0, RegWriteW}, 32'd0);
        chk("rst_pcW", PCPlus4W, 32'd0);
        chk("rst_rdW", ReadDataW, 32'd0);
        chk("rst_stall", {31'd0, stallM}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rd = 5'(i + 1);
            pc = 32'h100 + 32'(4 * i);
            drive(v[i], rd, pc);
            #1;
            chk({v[i].name, "_stall"}, {31'd0, stallM}, 32'd0);
            chk({v[i].name, "_req"}, {31'd0, dmem_req}, {31'd0, v[i].e_req});
            if (v[i].e_req) begin
                chk({v[i].name, "_addr"}, dmem_addr, {v[i].alu[31:2], 2'b00});
                chk({v[i].name, "_we"}, {31'd0, dmem_we}, {31'd0, v[i].mwe});
                if (v[i].mwe) begin
                    chk({v[i].name, "_be"}, {28'd0, dmem_be}, {28'd0, v[i].e_be});
                    chk({v[i].name, "_wdata"}, dmem_wdata, v[i].e_wdata);
                end
            end
            @(posedge clk);
            #1;
            chk({v[i].name, "_vldW"}, {31'd0, insn_vldW}, {31'd0, v[i].e_vldW});
            chk({v[i].name, "_regW"}, {31'd0, RegWriteW}, {31'd0, v[i].e_regW});
            chk({v[i].name, "_rdataW"}, ReadDataW, v[i].e_rdW);
            chk({v[i].name, "_excW"}, {30'd0, excW}, {30'd0, v[i].e_exc});
            chk({v[i].name, "_aluW"}, ALU_ResultW, v[i].alu);
            chk({v[i].name, "_pcW"}, PCPlus4W, pc);
            chk({v[i].name, "_RdW"}, {27'd0, RdW}, {27'd0, rd});
            chk({v[i].name, "_srcW"}, {30'd0, ResultSrcW}, {30'd0, v[i].rsrc});
        end

        // LB with ack two cycles late: two bubbles then the sign-extended byte
        @(negedge clk);
        nop();
        insn_vldM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 2'b01; funct3M = 3'b000;
        RdM = 5'd9; ALU_ResultM = 32'h0000_2001; PCPlus4M = 32'h200;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("lbw_stall", {31'd0, stallM}, 32'd1);
            chk("lbw_req", {31'd0, dmem_req}, 32'd1);
            @(posedge clk);
            #1;
            chk("lbw_bubble", {31'd0, insn_vldW}, 32'd0);
            @(negedge clk);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h0080_FF00;
        #1;
        chk("lbw_nostall", {31'd0, stallM}, 32'd0);
        @(posedge clk);
        #1;
        chk("lbw_vldW", {31'd0, insn_vldW}, 32'd1);
        chk("lbw_rdataW", ReadDataW, 32'hFFFF_FFFF);
        chk("lbw_regW", {31'd0, RegWriteW}, 32'd1);

        // LW with no ack: four stalled cycles, then bus-error completion
        @(negedge clk);
        nop();
        insn_vldM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 2'b01; funct3M = 3'b010;
        RdM = 5'd10; ALU_ResultM = 32'h0000_3000; PCPlus4M = 32'h300;
        nstall = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            was_stall = stallM;
            if (was_stall) nstall++;
            @(posedge clk);
            #1;
            if (!was_stall) break;
            chk("to_bubble", {31'd0, insn_vldW}, 32'd0);
            @(negedge clk);
        end
        chk("to_nstall", 32'(nstall), 32'd4);
        chk("to_excW", {30'd0, excW}, 32'd2);
        chk("to_vldW", {31'd0, insn_vldW}, 32'd1);
        chk("to_regW", {31'd0, RegWriteW}, 32'd0);
        chk("to_rdataW", ReadDataW, 32'd0);
        @(negedge clk);
        nop();
        #1;
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);

        // Same LW again, reset asserted mid-WAIT while the inputs persist
        @(negedge clk);
        insn_vldM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 2'b01; funct3M = 3'b010;
        RdM = 5'd11; ALU_ResultM = 32'h0000_3000; PCPlus4M = 32'h304;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_stall", {31'd0, stallM}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stallM}, 32'd0);
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_pcW", PCPlus4W, 32'd0);
        chk("mid_rst_aluW", ALU_ResultW, 32'd0);
        chk("mid_rst_excW", {30'd0, excW}, 32'd0);
        @(negedge clk);
        nop();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        #1;
        chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, stallM}, 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_vldW", {31'd0, insn_vldW}, 32'd0);
        chk("late_ack_excW", {30'd0, excW}, 32'd0);

        // State must be IDLE: a fresh LW without ack stalls with req high
        @(negedge clk);
        dmem_ack = 1'b0;
        insn_vldM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 2'b01; funct3M = 3'b010;
        ALU_ResultM = 32'h0000_3000;
        #1;
        chk("post_rst_req", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("post_rst_rdataW", ReadDataW, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
